// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the 4-channel TDM demultiplexer.
package tdm_demux_pkg;

    localparam int NUM_CH = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    typedef logic [1:0] slot_t;

    localparam slot_t CH_A = 2'd0;
    localparam slot_t CH_B = 2'd1;
    localparam slot_t CH_C = 2'd2;
    localparam slot_t CH_D = 2'd3;

    function automatic logic [NUM_CH-1:0] ch_onehot(input slot_t ch);
        return NUM_CH'(1) << ch;
    endfunction

endpackage

// File: rtl/tdm_slot_tracker.sv
// Frame assembly control: decides which shadow slot each word fills, when a frame
// commits and when a partial frame is aborted.
module tdm_slot_tracker
    import tdm_demux_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    input  logic              sof,
    input  logic              mode,
    input  logic [1:0]        sel,
    output logic [NUM_CH-1:0] we,
    output logic              commit,
    output logic              abort,
    output logic              busy
);

    state_t            state, state_nxt;
    slot_t             slot, slot_nxt;
    logic [NUM_CH-1:0] mask, mask_nxt;
    logic              mode_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            slot   <= CH_A;
            mask   <= '0;
            mode_q <= mode;
        end else begin
            state  <= state_nxt;
            slot   <= slot_nxt;
            mask   <= mask_nxt;
            mode_q <= mode;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        mask_nxt  = mask;
        we        = '0;
        commit    = 1'b0;
        abort     = 1'b0;

        if (mode != mode_q) begin
            // Addressing scheme changed under us: drop any partial frame and this word.
            abort     = (mask != '0);
            mask_nxt  = '0;
            slot_nxt  = CH_A;
            state_nxt = IDLE;
        end else if (din_valid) begin
            if (mode) begin
                if (sof) begin
                    abort     = (state == COLLECT);
                    we        = ch_onehot(CH_A);
                    mask_nxt  = ch_onehot(CH_A);
                    slot_nxt  = CH_B;
                    state_nxt = COLLECT;
                end else if (state == COLLECT) begin
                    we = ch_onehot(slot);
                    if (slot == CH_D) begin
                        commit    = 1'b1;
                        mask_nxt  = '0;
                        slot_nxt  = CH_A;
                        state_nxt = IDLE;
                    end else begin
                        mask_nxt = mask | ch_onehot(slot);
                        slot_nxt = slot + 2'd1;
                    end
                end
            end else begin
                // Abort clears the mask before the current word is applied.
                if (sof && (mask != '0)) begin
                    abort    = 1'b1;
                    mask_nxt = '0;
                end
                we       = ch_onehot(sel);
                mask_nxt = mask_nxt | ch_onehot(sel);
                if (mask_nxt == '1) begin
                    commit   = 1'b1;
                    mask_nxt = '0;
                end
                state_nxt = IDLE;
            end
        end
    end

    assign busy = (mask != '0);

endmodule

// File: rtl/tdm_demultiplexer.sv
// 1:4 TDM demultiplexer: gathers words into shadow registers and commits all four
// channel outputs together once a full frame has arrived.
module tdm_demultiplexer
    import tdm_demux_pkg::*;
#(
    parameter int W     = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     din,
    input  logic             din_valid,
    input  logic             sof,
    input  logic             mode,
    input  logic [1:0]       sel,
    output logic [W-1:0]     a,
    output logic [W-1:0]     b,
    output logic [W-1:0]     c,
    output logic [W-1:0]     d,
    output logic             frame_done,
    output logic             err_abort,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    logic [NUM_CH-1:0] we;
    logic              commit;
    logic              abort;
    logic [W-1:0]      shadow [NUM_CH];

    tdm_slot_tracker u_tracker (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .sof       (sof),
        .mode      (mode),
        .sel       (sel),
        .we        (we),
        .commit    (commit),
        .abort     (abort),
        .busy      (busy)
    );

    // NOTE: the shadow array is small and its reset value is observable, so it is
    // reset explicitly rather than left as an unreset storage array.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (we[i]) shadow[i] <= din;
            end
        end
    end

    // The completing word bypasses the shadow so outputs land one clock after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            a          <= '0;
            b          <= '0;
            c          <= '0;
            d          <= '0;
            frame_done <= 1'b0;
            err_abort  <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= commit;
            err_abort  <= abort;
            if (commit) begin
                a         <= we[CH_A] ? din : shadow[CH_A];
                b         <= we[CH_B] ? din : shadow[CH_B];
                c         <= we[CH_C] ? din : shadow[CH_C];
                d         <= we[CH_D] ? din : shadow[CH_D];
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Directed self-checking bench for tdm_demultiplexer; a second instance with a
// 2-bit frame counter exercises counter wrap.
module tb_tdm_demultiplexer;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] din;
    logic       din_valid;
    logic       sof;
    logic       mode;
    logic [1:0] sel;

    logic [1:0] a, b, c, d;
    logic       frame_done, err_abort, busy;
    logic [7:0] frame_cnt;

    logic [1:0] a2, b2, c2, d2;
    logic       frame_done2, err_abort2, busy2;
    logic [1:0] frame_cnt2;

    int vectors     = 0;
    int miscompares = 0;
    int n_done      = 0;
    int n_abort     = 0;
    int n_both      = 0;

    always #5 clk = ~clk;

    tdm_demultiplexer #(.W(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
        .mode(mode), .sel(sel), .a(a), .b(b), .c(c), .d(d),
        .frame_done(frame_done), .err_abort(err_abort), .busy(busy),
        .frame_cnt(frame_cnt)
    );

    tdm_demultiplexer #(.W(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
        .mode(mode), .sel(sel), .a(a2), .b(b2), .c(c2), .d(d2),
        .frame_done(frame_done2), .err_abort(err_abort2), .busy(busy2),
        .frame_cnt(frame_cnt2)
    );

    // Inputs change on the falling edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        n_done  += int'(frame_done);
        n_abort += int'(err_abort);
        if (frame_done && err_abort) n_both++;
    endtask

    task automatic send(input logic [1:0] w, input logic s, input logic [1:0] sl);
        din       = w;
        sof       = s;
        sel       = sl;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        sof       = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if ({a, b, c, d} !== 8'h00 || frame_cnt !== 8'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL por_state: abcd=%b cnt=%0d busy=%b, want 0/0/0", {a, b, c, d}, frame_cnt, busy);
        end
        send(2'b11, 1'b1, 2'b00);
        send(2'b10, 1'b0, 2'b00);
        send(2'b01, 1'b0, 2'b00);
        send(2'b11, 1'b0, 2'b00);
        vectors++;
        if ({a, b, c, d} !== 8'b11100111) begin
            miscompares++;
            $display("FAIL pre_reset_frame: abcd=%b want 11100111", {a, b, c, d});
        end
        send(2'b01, 1'b1, 2'b00);
        send(2'b10, 1'b0, 2'b00);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL partial_busy: busy=%b want 1", busy);
        end
        rst       = 1'b1;
        din_valid = 1'b1;
        din       = 2'b11;
        tick();
        tick();
        vectors++;
        if ({a, b, c, d} !== 8'h00 || frame_cnt !== 8'd0 || busy !== 1'b0 ||
            frame_done !== 1'b0 || err_abort !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: abcd=%b cnt=%0d busy=%b done=%b abort=%b, want all 0",
                     {a, b, c, d}, frame_cnt, busy, frame_done, err_abort);
        end
        rst       = 1'b0;
        din_valid = 1'b0;
        tick();
        vectors++;
        if (err_abort !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset: abort=%b busy=%b, want 0/0", err_abort, busy);
        end
    endtask

    task automatic test_auto_frame();
        n_done = 0;
        send(2'b00, 1'b1, 2'b00);
        send(2'b01, 1'b0, 2'b00);
        send(2'b01, 1'b0, 2'b00);
        vectors++;
        if ({a, b, c, d} !== 8'h00 || frame_done !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL auto_hold: abcd=%b done=%b busy=%b, want 00000000/0/1", {a, b, c, d}, frame_done, busy);
        end
        send(2'b11, 1'b0, 2'b00);
        vectors++;
        if ({a, b, c, d} !== 8'b00010111 || frame_done !== 1'b1 || frame_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL auto_commit: abcd=%b done=%b cnt=%0d, want 00010111/1/1", {a, b, c, d}, frame_done, frame_cnt);
        end
        tick();
        vectors++;
        if (frame_done !== 1'b0 || n_done != 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL auto_pulse: done=%b pulses=%0d busy=%b, want 0/1/0", frame_done, n_done, busy);
        end
    endtask

    task automatic test_auto_abort();
        n_abort = 0;
        send(2'b10, 1'b1, 2'b00);
        send(2'b11, 1'b0, 2'b00);
        send(2'b01, 1'b1, 2'b00);
        vectors++;
        if (err_abort !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL auto_abort: abort=%b busy=%b, want 1/1", err_abort, busy);
        end
        send(2'b00, 1'b0, 2'b00);
        send(2'b11, 1'b0, 2'b00);
        send(2'b10, 1'b0, 2'b00);
        vectors++;
        if ({a, b, c, d} !== 8'b01001110 || frame_cnt !== 8'd2 || frame_done !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_refill: abcd=%b cnt=%0d done=%b, want 01001110/2/1", {a, b, c, d}, frame_cnt, frame_done);
        end
        tick();
        vectors++;
        if (n_abort != 1) begin
            miscompares++;
            $display("FAIL abort_count: pulses=%0d want 1", n_abort);
        end
    endtask

    task automatic test_explicit();
        mode = 1'b0;
        tick();
        n_abort = 0;
        send(2'b11, 1'b0, 2'b11);
        send(2'b01, 1'b0, 2'b00);
        send(2'b10, 1'b0, 2'b10);
        send(2'b00, 1'b0, 2'b00);
        vectors++;
        if ({a, b, c, d} !== 8'b01001110 || busy !== 1'b1 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL explicit_hold: abcd=%b busy=%b done=%b, want 01001110/1/0", {a, b, c, d}, busy, frame_done);
        end
        send(2'b01, 1'b0, 2'b01);
        vectors++;
        if ({a, b, c, d} !== 8'b00011011 || frame_done !== 1'b1 || frame_cnt !== 8'd3) begin
            miscompares++;
            $display("FAIL explicit_commit: abcd=%b done=%b cnt=%0d, want 00011011/1/3", {a, b, c, d}, frame_done, frame_cnt);
        end
        tick();
        vectors++;
        if (n_abort != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL explicit_noerr: aborts=%0d busy=%b, want 0/0", n_abort, busy);
        end
    endtask

    task automatic test_mode_switch();
        send(2'b10, 1'b0, 2'b00);
        send(2'b11, 1'b0, 2'b01);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL switch_busy: busy=%b want 1", busy);
        end
        mode = 1'b1;
        tick();
        vectors++;
        if (err_abort !== 1'b1 || busy !== 1'b0 || {a, b, c, d} !== 8'b00011011 || frame_cnt !== 8'd3) begin
            miscompares++;
            $display("FAIL switch_abort: abort=%b busy=%b abcd=%b cnt=%0d, want 1/0/00011011/3",
                     err_abort, busy, {a, b, c, d}, frame_cnt);
        end
        tick();
        vectors++;
        if (err_abort !== 1'b0) begin
            miscompares++;
            $display("FAIL switch_pulse: abort=%b want 0", err_abort);
        end
    endtask

    task automatic test_cnt_wrap();
        logic [1:0] exp2 [5];
        exp2[0] = 2'd1; exp2[1] = 2'd2; exp2[2] = 2'd3; exp2[3] = 2'd0; exp2[4] = 2'd1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send(2'(k), 1'b1, 2'b00);
            tick();
            tick();
            vectors++;
            if (busy2 !== 1'b1) begin
                miscompares++;
                $display("FAIL gap_busy[%0d]: busy=%b want 1", k, busy2);
            end
            send(2'b01, 1'b0, 2'b00);
            tick();
            send(2'b10, 1'b0, 2'b00);
            send(2'b11, 1'b0, 2'b00);
            vectors++;
            if (frame_cnt2 !== exp2[k] || frame_cnt !== 8'(k + 1)) begin
                miscompares++;
                $display("FAIL cnt_wrap[%0d]: cnt2=%0d cnt=%0d, want %0d/%0d", k, frame_cnt2, frame_cnt, exp2[k], k + 1);
            end
        end
        vectors++;
        if ({a2, b2, c2, d2} !== 8'b00011011) begin
            miscompares++;
            $display("FAIL wrap_data: abcd=%b want 00011011", {a2, b2, c2, d2});
        end
    endtask

    initial begin
        rst       = 1'b1;
        din       = 2'b00;
        din_valid = 1'b0;
        sof       = 1'b0;
        mode      = 1'b1;
        sel       = 2'b00;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        test_reset();
        test_auto_frame();
        test_auto_abort();
        test_explicit();
        test_mode_switch();
        test_cnt_wrap();

        vectors++;
        if (n_both != 0) begin
            miscompares++;
            $display("FAIL done_and_abort: coincident pulses=%0d want 0", n_both);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
